i2s2_tx_serializer: RTL

- Playback back end of the AXI-I2S2 peripheral: buffers stereo PCM samples written through the AXI4-Lite register block and serializes them to the Pmod I2S2 DAC (CS4344) in I2S format.
- Generates MCLK, SCLK and LRCK from ACLK using a single phase counter, so all three clocks stay aligned.
- Sits directly downstream of the AXI4-Lite slave register file; consumes its sample-push handshake and returns FIFO/underrun status to it.

---
 rtl/i2s2_tx_pkg.sv | 25 ++
 rtl/i2s2_sample_fifo.sv | 47 ++++
 rtl/i2s2_tx_serializer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/i2s2_tx_pkg.sv
// Shared constants and types for the I2S2 playback serializer.
// The phase counter layout fixes where MCLK, SCLK, LRCK and the slot index sit.
package i2s2_tx_pkg;

  localparam int PHASE_W  = 9;
  localparam int SLOT_W   = 5;
  localparam int SCLK_BIT = 2;
  localparam int LRCK_BIT = 8;
  localparam int MAX_DW   = 31;

  localparam logic [PHASE_W-1:0] FRAME_LAST = 9'd511;

  // Widest legal channel word. Narrower samples are stored left-justified so the
  // MSB always leaves the shift register first.
  typedef struct packed {
    logic [MAX_DW-1:0] left;
    logic [MAX_DW-1:0] right;
  } stereo_t;

  function automatic logic [MAX_DW-1:0] justify(input logic [MAX_DW-1:0] value,
                                                input int              width);
    return value << (MAX_DW - width);
  endfunction

endpackage

// File: rtl/i2s2_sample_fifo.sv
// First-word-fall-through FIFO for stereo samples; occupancy is derived from
// wrap-bit pointers so full and empty never disagree with level.
module i2s2_sample_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign level    = wr_ptr - rd_ptr;
  assign full     = (level == (AW+1)'(DEPTH));
  assign empty    = (level == '0);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: the storage array is deliberately left without reset; the pointers
  // alone define which entries are valid, and this keeps it mappable to RAM.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/i2s2_tx_serializer.sv
// I2S playback back end: buffers stereo samples and shifts them out to the
// CS4344 with MCLK/SCLK/LRCK all decoded from one phase counter.
module i2s2_tx_serializer
  import i2s2_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int FIFO_DEPTH = 16,
  parameter int MCLK_HALF  = 2
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic                          enable,
  input  logic [2*DATA_WIDTH-1:0]       s_tdata,
  input  logic                          s_tvalid,
  output logic                          s_tready,
  input  logic                          clear_underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   underrun_count,
  output logic                          frame_start,
  output logic                          tx_mclk,
  output logic                          tx_sclk,
  output logic                          tx_lrck,
  output logic                          tx_sdout
);

  localparam int                 DIV_W     = (MCLK_HALF > 1) ? $clog2(MCLK_HALF) : 1;
  localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(MCLK_HALF - 1);
  localparam logic [SLOT_W-1:0]  LAST_SLOT = SLOT_W'(DATA_WIDTH);

  logic [DIV_W-1:0]          divider;
  logic [PHASE_W-1:0]        phase;
  logic [PHASE_W-1:0]        phase_nxt;
  logic [SLOT_W-1:0]         next_slot;
  logic                      tick;
  logic                      frame_load;
  logic                      bit_edge;
  logic                      data_slot;
  logic                      pop;
  logic                      underrun;
  logic                      push;
  logic                      full;
  logic                      empty;
  logic [2*DATA_WIDTH-1:0]   pop_data;
  stereo_t                   sample;
  logic [MAX_DW-1:0]         left_sr;
  logic [MAX_DW-1:0]         right_sr;

  // Ready is held low while reset is asserted and reflects only fullness after.
  assign s_tready = !full && !ARESET;
  assign push     = s_tvalid && s_tready;

  i2s2_sample_fifo #(
    .WIDTH (2*DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (ACLK),
    .rst       (ARESET),
    .push      (push),
    .push_data (s_tdata),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (full),
    .empty     (empty),
    .level     (fifo_level)
  );

  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    tick      = enable && (divider == DIV_LAST);
    phase_nxt = phase;
    if (!enable)   phase_nxt = '0;
    else if (tick) phase_nxt = phase + PHASE_W'(1);

    frame_load = tick && (phase == FRAME_LAST);
    bit_edge   = tick && (phase[SCLK_BIT:0] == '1);
    next_slot  = phase_nxt[LRCK_BIT-1:SCLK_BIT+1];
    data_slot  = (next_slot != '0) && (next_slot <= LAST_SLOT);
    pop        = frame_load && !empty;
    underrun   = frame_load && empty;

    sample.left  = justify(MAX_DW'(pop_data[2*DATA_WIDTH-1:DATA_WIDTH]), DATA_WIDTH);
    sample.right = justify(MAX_DW'(pop_data[DATA_WIDTH-1:0]), DATA_WIDTH);
  end

  // Clocks are registered from the next phase so a falling SCLK and the new
  // data bit leave the same flop edge.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      divider     <= '0;
      phase       <= '0;
      tx_mclk     <= 1'b0;
      tx_sclk     <= 1'b0;
      tx_lrck     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      divider     <= (!enable || tick) ? '0 : divider + DIV_W'(1);
      phase       <= phase_nxt;
      tx_mclk     <= phase_nxt[0];
      tx_sclk     <= phase_nxt[SCLK_BIT];
      tx_lrck     <= phase_nxt[LRCK_BIT];
      frame_start <= frame_load;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      left_sr  <= '0;
      right_sr <= '0;
      tx_sdout <= 1'b0;
    end else if (!enable) begin
      left_sr  <= '0;
      right_sr <= '0;
      tx_sdout <= 1'b0;
    end else if (frame_load) begin
      // Phase 0 is the I2S one-bit delay slot, so the line idles low here.
      left_sr  <= pop ? sample.left  : '0;
      right_sr <= pop ? sample.right : '0;
      tx_sdout <= 1'b0;
    end else if (bit_edge) begin
      if (!data_slot) begin
        tx_sdout <= 1'b0;
      end else if (phase_nxt[LRCK_BIT]) begin
        tx_sdout <= right_sr[MAX_DW-1];
        right_sr <= {right_sr[MAX_DW-2:0], 1'b0};
      end else begin
        tx_sdout <= left_sr[MAX_DW-1];
        left_sr  <= {left_sr[MAX_DW-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      underrun_count <= '0;
    end else if (clear_underrun) begin
      underrun_count <= '0;
    end else if (underrun && (underrun_count != 16'hFFFF)) begin
      underrun_count <= underrun_count + 16'd1;
    end
  end

endmodule
